// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt scheduler: default sizes, FSM encoding
// and the priority helper used for both candidate selection and eret retirement.
package irq_pkg;

  localparam int NIRQ_DEF     = 3;
  localparam int NBIT_IRQ_DEF = 2;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_REQ  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Index of the lowest set bit (highest priority); 32 when the vector is empty.
  function automatic logic [5:0] lowest_set(input logic [31:0] vec);
    logic [5:0] idx;
    idx = 6'd32;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// One interrupt line: three-flop synchroniser with a single-cycle rising-edge
// pulse taken from the two settled stages.
module irq_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic src,
  output logic rise
);

  logic s1_reg;
  logic s2_reg;
  logic s3_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= src;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign rise = s2_reg & ~s3_reg;

endmodule

// File: rtl/irq_sched_ctl.sv
// Interrupt scheduler: latches synchronised edges as pending requests, presents
// the highest-priority eligible one to ID and tracks nesting via in-service bits.
module irq_sched_ctl
  import irq_pkg::*;
#(
  parameter int NIRQ     = NIRQ_DEF,
  parameter int NBIT_IRQ = NBIT_IRQ_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NIRQ-1:0]     irq_src,
  input  logic                ie,
  input  logic                irq_ack,
  input  logic                irq_eret,
  output logic                ivld,
  output logic [NBIT_IRQ-1:0] inum,
  output logic [NIRQ-1:0]     pend,
  output logic [NIRQ-1:0]     insvc,
  output logic                err
);

  logic [NIRQ-1:0]     rise_vec;
  logic [NIRQ-1:0]     pend_reg;
  logic [NIRQ-1:0]     pend_next;
  logic [NIRQ-1:0]     insvc_reg;
  logic [NIRQ-1:0]     insvc_next;
  logic [NIRQ-1:0]     ack_hit;
  logic [NIRQ-1:0]     elig;
  state_t              state_reg;
  logic [1:0]          arm_cnt_reg;
  logic                ivld_reg;
  logic                err_reg;
  logic [NBIT_IRQ-1:0] inum_reg;
  logic [5:0]          top_idx;
  logic [5:0]          cand_idx;
  logic                cand_vld;
  logic                ack_ok;
  logic                ack_bad;
  logic                eret_ok;
  logic                eret_bad;

  genvar gi;
  generate
    for (gi = 0; gi < NIRQ; gi++) begin : g_src
      irq_edge_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .src  (irq_src[gi]),
        .rise (rise_vec[gi])
      );
      assign ack_hit[gi] = ack_ok && (inum_reg == NBIT_IRQ'(gi));
      // Only sources strictly above the current in-service level may nest.
      assign elig[gi]    = pend_reg[gi] && (6'(gi) < top_idx);
    end
  endgenerate

  assign top_idx  = lowest_set(32'(insvc_reg));
  assign cand_idx = lowest_set(32'(elig));
  assign cand_vld = (cand_idx != 6'd32);

  assign ack_ok   = en && irq_ack && (state_reg == ST_REQ);
  assign ack_bad  = irq_ack && (state_reg != ST_REQ);
  assign eret_ok  = en && irq_eret && (insvc_reg != '0);
  assign eret_bad = en && irq_eret && (insvc_reg == '0);

  // Edge set is ORed after the ack clear so a coincident new edge survives.
  assign pend_next  = (pend_reg & ~ack_hit) | (rise_vec & {NIRQ{state_reg != ST_ARM}});
  assign insvc_next = (eret_ok ? (insvc_reg & (insvc_reg - NIRQ'(1))) : insvc_reg) | ack_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_ARM;
      arm_cnt_reg <= 2'd0;
      ivld_reg    <= 1'b0;
      inum_reg    <= '0;
      pend_reg    <= '0;
      insvc_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      err_reg  <= err_reg | ack_bad | eret_bad;
      pend_reg <= pend_next;
      if (en) begin
        insvc_reg <= insvc_next;
        case (state_reg)
          ST_ARM: begin
            if (arm_cnt_reg == 2'd2) state_reg <= ST_IDLE;
            else                     arm_cnt_reg <= arm_cnt_reg + 2'd1;
          end
          ST_IDLE: begin
            if (ie && cand_vld) begin
              state_reg <= ST_REQ;
              inum_reg  <= cand_idx[NBIT_IRQ-1:0];
              ivld_reg  <= 1'b1;
            end
          end
          ST_REQ: begin
            if (irq_ack) begin
              state_reg <= ST_GAP;
              ivld_reg  <= 1'b0;
            end else if (!ie) begin
              state_reg <= ST_IDLE;
              ivld_reg  <= 1'b0;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            ivld_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ivld  = ivld_reg;
  assign inum  = inum_reg;
  assign pend  = pend_reg;
  assign insvc = insvc_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_irq_sched_ctl.sv
// Scenario bench for irq_sched_ctl: inline checks per task plus a request
// scoreboard that matches every ivld rise against the expected inum.
module tb_irq_sched_ctl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] irq_src;
  logic       ie;
  logic       irq_ack;
  logic       irq_eret;
  logic       ivld;
  logic [1:0] inum;
  logic [2:0] pend;
  logic [2:0] insvc;
  logic       err;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_inum;
  logic       prev_ivld = 1'b0;

  irq_sched_ctl dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .irq_src  (irq_src),
    .ie       (ie),
    .irq_ack  (irq_ack),
    .irq_eret (irq_eret),
    .ivld     (ivld),
    .inum     (inum),
    .pend     (pend),
    .insvc    (insvc),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each new request presented to ID consumes one expected inum.
  always @(negedge clk) begin
    if (ivld === 1'b1 && prev_ivld !== 1'b1) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL sb_unexpected: got ivld=1 inum=%0d, required no request", inum);
      end else begin
        exp_inum = exp_q.pop_front();
        if (inum !== exp_inum) begin
          err_cnt++;
          $display("FAIL sb_inum: got %0d required %0d", inum, exp_inum);
        end else begin
          $display("sb: request inum=%0d matched", inum);
        end
      end
    end
    prev_ivld = ivld;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] src);
    rst = 1'b1; en = 1'b1; ie = 1'b1; irq_ack = 1'b0; irq_eret = 1'b0; irq_src = src;
    step(2);
    rst = 1'b0;
    step(4);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; ie = 1'b0; irq_ack = 1'b0; irq_eret = 1'b0; irq_src = 3'b000;
    step(2);
    vec_cnt++; if (ivld !== 1'b0) begin err_cnt++; $display("FAIL reset_ivld: got %b required 0", ivld); end
    vec_cnt++; if (inum !== 2'd0) begin err_cnt++; $display("FAIL reset_inum: got %0d required 0", inum); end
    vec_cnt++; if (pend !== 3'b000) begin err_cnt++; $display("FAIL reset_pend: got %b required 000", pend); end
    vec_cnt++; if (insvc !== 3'b000) begin err_cnt++; $display("FAIL reset_insvc: got %b required 000", insvc); end
    vec_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL reset_err: got %b required 0", err); end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    do_reset(3'b000);
    exp_q.push_back(2'd1);
    irq_src = 3'b010;
    step(3);
    vec_cnt++; if (ivld !== 1'b0) begin err_cnt++; $display("FAIL basic_early: got ivld=%b required 0 at +3", ivld); end
    step(1);
    vec_cnt++; if (ivld !== 1'b1 || inum !== 2'd1) begin err_cnt++; $display("FAIL basic_req: got ivld=%b inum=%0d required 1/1 at +4", ivld, inum); end
    irq_src = 3'b000;
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    vec_cnt++; if (insvc !== 3'b010 || pend !== 3'b000 || ivld !== 1'b0) begin err_cnt++; $display("FAIL basic_ack: got insvc=%b pend=%b ivld=%b required 010/000/0", insvc, pend, ivld); end
    step(3);
    vec_cnt++; if (ivld !== 1'b0 || err !== 1'b0) begin err_cnt++; $display("FAIL basic_after: got ivld=%b err=%b required 0/0", ivld, err); end
    $display("test_basic done");
  endtask

  task automatic test_arm;
    rst = 1'b1; en = 1'b1; ie = 1'b1; irq_ack = 1'b0; irq_eret = 1'b0; irq_src = 3'b111;
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      vec_cnt++; if (ivld !== 1'b0 || pend !== 3'b000) begin err_cnt++; $display("FAIL arm_cyc%0d: got ivld=%b pend=%b required 0/000", i, ivld, pend); end
    end
    irq_src = 3'b011;
    step(2);
    exp_q.push_back(2'd2);
    irq_src = 3'b111;
    step(4);
    vec_cnt++; if (ivld !== 1'b1 || inum !== 2'd2) begin err_cnt++; $display("FAIL arm_reraise: got ivld=%b inum=%0d required 1/2", ivld, inum); end
    $display("test_arm done");
  endtask

  task automatic test_nesting;
    do_reset(3'b000);
    exp_q.push_back(2'd2);
    irq_src = 3'b100;
    step(4);
    vec_cnt++; if (ivld !== 1'b1 || inum !== 2'd2) begin err_cnt++; $display("FAIL nest_req2: got ivld=%b inum=%0d required 1/2", ivld, inum); end
    irq_src = 3'b000;
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    vec_cnt++; if (insvc !== 3'b100) begin err_cnt++; $display("FAIL nest_insvc100: got %b required 100", insvc); end
    step(2);
    exp_q.push_back(2'd0);
    irq_src = 3'b001;
    step(4);
    vec_cnt++; if (ivld !== 1'b1 || inum !== 2'd0) begin err_cnt++; $display("FAIL nest_req0: got ivld=%b inum=%0d required 1/0", ivld, inum); end
    irq_src = 3'b000;
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    vec_cnt++; if (insvc !== 3'b101) begin err_cnt++; $display("FAIL nest_insvc101: got %b required 101", insvc); end
    irq_eret = 1'b1; step(1); irq_eret = 1'b0;
    vec_cnt++; if (insvc !== 3'b100) begin err_cnt++; $display("FAIL nest_eret1: got %b required 100", insvc); end
    irq_src = 3'b100;
    step(6);
    vec_cnt++; if (ivld !== 1'b0 || pend !== 3'b100) begin err_cnt++; $display("FAIL nest_blocked: got ivld=%b pend=%b required 0/100", ivld, pend); end
    irq_src = 3'b000;
    exp_q.push_back(2'd2);
    irq_eret = 1'b1; step(1); irq_eret = 1'b0;
    vec_cnt++; if (insvc !== 3'b000) begin err_cnt++; $display("FAIL nest_eret2: got %b required 000", insvc); end
    step(1);
    vec_cnt++; if (ivld !== 1'b1 || inum !== 2'd2) begin err_cnt++; $display("FAIL nest_unblock: got ivld=%b inum=%0d required 1/2", ivld, inum); end
    $display("test_nesting done");
  endtask

  task automatic test_withdraw;
    do_reset(3'b000);
    exp_q.push_back(2'd1);
    irq_src = 3'b010;
    step(4);
    irq_src = 3'b000;
    ie = 1'b0;
    step(1);
    vec_cnt++; if (ivld !== 1'b0 || pend !== 3'b010) begin err_cnt++; $display("FAIL wd_drop: got ivld=%b pend=%b required 0/010", ivld, pend); end
    exp_q.push_back(2'd1);
    ie = 1'b1;
    step(1);
    vec_cnt++; if (ivld !== 1'b1 || inum !== 2'd1) begin err_cnt++; $display("FAIL wd_rearm: got ivld=%b inum=%0d required 1/1", ivld, inum); end
    irq_ack = 1'b1; ie = 1'b0;
    step(1);
    irq_ack = 1'b0; ie = 1'b1;
    vec_cnt++; if (ivld !== 1'b0 || insvc !== 3'b010 || pend !== 3'b000) begin err_cnt++; $display("FAIL wd_ack_noie: got ivld=%b insvc=%b pend=%b required 0/010/000", ivld, insvc, pend); end
    step(2);
    vec_cnt++; if (ivld !== 1'b0 || err !== 1'b0) begin err_cnt++; $display("FAIL wd_after: got ivld=%b err=%b required 0/0", ivld, err); end
    $display("test_withdraw done");
  endtask

  task automatic test_stall;
    do_reset(3'b000);
    exp_q.push_back(2'd1);
    irq_src = 3'b010;
    step(4);
    irq_src = 3'b000;
    en = 1'b0;
    irq_src = 3'b001;
    step(2);
    irq_src = 3'b000;
    step(3);
    vec_cnt++; if (ivld !== 1'b1 || inum !== 2'd1) begin err_cnt++; $display("FAIL stall_hold: got ivld=%b inum=%0d required 1/1", ivld, inum); end
    vec_cnt++; if (pend !== 3'b011) begin err_cnt++; $display("FAIL stall_pend: got %b required 011", pend); end
    en = 1'b1;
    exp_q.push_back(2'd0);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    vec_cnt++; if (ivld !== 1'b0 || insvc !== 3'b010) begin err_cnt++; $display("FAIL stall_gap: got ivld=%b insvc=%b required 0/010", ivld, insvc); end
    step(1);
    vec_cnt++; if (ivld !== 1'b0) begin err_cnt++; $display("FAIL stall_gap2: got ivld=%b required 0", ivld); end
    step(1);
    vec_cnt++; if (ivld !== 1'b1 || inum !== 2'd0) begin err_cnt++; $display("FAIL stall_next: got ivld=%b inum=%0d required 1/0", ivld, inum); end
    $display("test_stall done");
  endtask

  task automatic test_err;
    do_reset(3'b000);
    vec_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL err_init: got %b required 0", err); end
    irq_eret = 1'b1; step(1); irq_eret = 1'b0;
    vec_cnt++; if (err !== 1'b1 || insvc !== 3'b000) begin err_cnt++; $display("FAIL err_eret: got err=%b insvc=%b required 1/000", err, insvc); end
    step(3);
    vec_cnt++; if (err !== 1'b1) begin err_cnt++; $display("FAIL err_sticky: got %b required 1", err); end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    vec_cnt++; if (err !== 1'b1 || insvc !== 3'b000 || ivld !== 1'b0) begin err_cnt++; $display("FAIL err_ack_idle: got err=%b insvc=%b ivld=%b required 1/000/0", err, insvc, ivld); end
    $display("test_err done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arm();
    test_nesting();
    test_withdraw();
    test_stall();
    test_err();
    step(2);
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL sb_leftover: got %0d unmatched requests required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
